stream_moving_average: RTL
==========================

Name: stream_moving_average

Overview:
- Avalon-ST processing stage between the SoC streaming sink and streaming source in the top-level DSP datapath; replaces the current straight wire-through.
- Computes a running mean over the last 2^LOG2_TAPS signed 16-bit samples.
- startofpacket and endofpacket travel with their samples.
- Controlled by CSR fields (enable, clear-on-SOP); reports a processed-sample counter back to CSR.

Parameters:
- DATA_W, 16, sample width (signed two's complement).
- LOG2_TAPS, 3, log2 of window length; TAPS = 2^LOG2_TAPS; legal range 1..6.
- CNT_W, 32, width of the output sample counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sink_data  in  DATA_W  input sample
- sink_valid  in  1  input sample valid
- sink_startofpacket  in  1  first sample of packet
- sink_endofpacket  in  1  last sample of packet
- sink_ready  out  1  block accepts a sample this cycle
- source_data  out  DATA_W  filtered sample
- source_valid  out  1  output valid
- source_startofpacket  out  1  SOP aligned with source_data
- source_endofpacket  out  1  EOP aligned with source_data
- source_ready  in  1  downstream accepts
- cfg_enable  in  1  1 = average, 0 = bypass (CSR)
- cfg_clear_on_sop  in  1  1 = flush history at each SOP (CSR)
- sample_count  out  CNT_W  number of output transfers since reset (CSR status)

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: source_valid=0, source_data=0, source_startofpacket=0, source_endofpacket=0, sample_count=0, history=0, accumulator=0.
- Handshake:
  - sink_ready = !source_valid || source_ready (combinational).
  - Accept = sink_valid && sink_ready. Output transfer = source_valid && source_ready.
- Output register:
  - On accept: source_* loaded, source_valid set next cycle.
  - On output transfer with no accept: source_valid cleared.
  - On output transfer with accept in the same cycle: register reloaded, source_valid stays 1.
  - Holding: source_* stable while source_valid && !source_ready.
- Latency: 1 cycle from accept to source_valid. Full throughput of 1 sample/cycle while source_ready=1.
- Datapath (enable=1):
  - Delay line of TAPS samples; ACC_W = DATA_W+LOG2_TAPS bits, signed.
  - On accept: acc_nxt = acc + sext(x) - sext(oldest); history shifts in x, drops oldest.
  - source_data = acc_nxt >>> LOG2_TAPS (arithmetic, floor rounding). Never overflows.
- Clear-on-SOP: if cfg_clear_on_sop=1 and the accepted sample has SOP=1, history and acc are treated as zero before the update. Result: acc_nxt = x, history = {x, 0, ..., 0}.
- Bypass (enable=0):
  - source_data = x, same 1-cycle latency and handshake.
  - History and acc held at zero, so re-enabling starts from a clean window.
- Enable change: sampled per accepted sample. Toggling mid-packet is legal; there is no partial-window blending beyond the rules above.
- sample_count: +1 per output transfer, wraps at 2^CNT_W-1 -> 0.
- Back-pressure: no sample is lost or duplicated. History updates only on accept, never on a stalled cycle.
- SOP/EOP are copied unchanged from the accepted sample. No packet framing checks; a missing EOP is passed as-is.
- Reset mid-operation: all state returns to reset values immediately (async). The in-flight output sample is discarded.

Decomposition:
- Shared dsp_pkg:
  - SAMPLE_W = 16, sample_t (signed [SAMPLE_W-1:0]).
  - Default LOG2_TAPS constant.
  - CSR field-width constants for enable, clear_on_sop and sample_count.
- One sub-module, ma_delay_line:
  - TAPS-deep shift register with shift-enable and synchronous clear.
  - Exposes the oldest sample.
- Accumulator, output register and handshake stay in the top of the block.

Test Plan:
- Step response, TAPS=8: 12 back-to-back samples of 800, source_ready=1 -> outputs 100, 200, ..., 800, then 800 held; one output per cycle, latency 1.
- Negative floor rounding: single sample -1 then 7 zeros -> outputs -1 (acc -1 >>> 3) for 8 cycles, then 0. Input -32768 repeated 8 times -> -32768, no wrap.
- Back-pressure: source_ready toggles 1,0,0,1,... during step stimulus.
  - sink_ready=0 whenever source_valid && !source_ready.
  - Output sequence identical to the first test; source_data stable while stalled.
- Clear-on-SOP: packet A of eight 400s, then packet B starting with 80 with SOP=1.
  - clear_on_sop=1 -> first B output = 10.
  - clear_on_sop=0 -> first B output = (7*400+80)/8 = 360.
- Bypass: cfg_enable=0, inputs 5, -3, 1000 -> outputs 5, -3, 1000.
  - Then enable=1 with input 800 -> output 100 (clean history).
- Reset mid-stream plus counter: assert rst_n low while source_valid=1.
  - Outputs zero asynchronously, sample_count=0.
  - After release, a step of 800 restarts at 100; sample_count equals the number of output transfers.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP datapath types and CSR field widths.
package dsp_pkg;

  localparam int SAMPLE_W = 16;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int DEFAULT_LOG2_TAPS = 3;

  localparam int CSR_ENABLE_W       = 1;
  localparam int CSR_CLEAR_ON_SOP_W = 1;
  localparam int CSR_SAMPLE_COUNT_W = 32;

endpackage

// File: rtl/ma_delay_line.sv
// Sample history for the moving average: shift register with shift-enable and
// synchronous clear; clear together with shift leaves only the new sample.
module ma_delay_line #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] oldest
);

  logic [DATA_W-1:0] taps [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (clear) begin
      taps[0] <= shift_en ? din : '0;
      for (int i = 1; i < DEPTH; i++) taps[i] <= '0;
    end else if (shift_en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign oldest = taps[DEPTH-1];

endmodule

// File: rtl/stream_moving_average.sv
// Avalon-ST running mean over the last 2^LOG2_TAPS signed samples, with bypass,
// clear-on-SOP and an output transfer counter.
module stream_moving_average
  import dsp_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int LOG2_TAPS = DEFAULT_LOG2_TAPS,
  parameter int CNT_W     = CSR_SAMPLE_COUNT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             sink_data,
  input  logic                          sink_valid,
  input  logic                          sink_startofpacket,
  input  logic                          sink_endofpacket,
  output logic                          sink_ready,
  output logic [DATA_W-1:0]             source_data,
  output logic                          source_valid,
  output logic                          source_startofpacket,
  output logic                          source_endofpacket,
  input  logic                          source_ready,
  input  logic [CSR_ENABLE_W-1:0]       cfg_enable,
  input  logic [CSR_CLEAR_ON_SOP_W-1:0] cfg_clear_on_sop,
  output logic [CNT_W-1:0]              sample_count
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int ACC_W = DATA_W + LOG2_TAPS;

  logic                    accept;
  logic                    xfer;
  logic                    flush;
  logic [DATA_W-1:0]       oldest;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] old_ext;
  logic [DATA_W-1:0]       avg;

  assign sink_ready = !source_valid || source_ready;
  assign accept     = sink_valid && sink_ready;
  assign xfer       = source_valid && source_ready;
  assign flush      = cfg_clear_on_sop[0] && sink_startofpacket;

  // A flushed window behaves as if history and accumulator were already zero.
  always_comb begin
    x_ext    = {{LOG2_TAPS{sink_data[DATA_W-1]}}, sink_data};
    old_ext  = {{LOG2_TAPS{oldest[DATA_W-1]}}, oldest};
    acc_base = acc_q;
    if (flush) begin
      old_ext  = '0;
      acc_base = '0;
    end
    acc_nxt = acc_base + x_ext - old_ext;
  end

  // Upper bits of the accumulator are the floor-rounded arithmetic shift.
  assign avg = acc_nxt[ACC_W-1:LOG2_TAPS];

  ma_delay_line #(
    .DATA_W (DATA_W),
    .DEPTH  (TAPS)
  ) u_delay_line (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept && cfg_enable[0]),
    .clear    (accept && (!cfg_enable[0] || flush)),
    .din      (sink_data),
    .oldest   (oldest)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= cfg_enable[0] ? acc_nxt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      source_valid         <= 1'b0;
      source_data          <= '0;
      source_startofpacket <= 1'b0;
      source_endofpacket   <= 1'b0;
    end else if (accept) begin
      source_valid         <= 1'b1;
      source_data          <= cfg_enable[0] ? avg : sink_data;
      source_startofpacket <= sink_startofpacket;
      source_endofpacket   <= sink_endofpacket;
    end else if (xfer) begin
      source_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= '0;
    end else if (xfer) begin
      sample_count <= sample_count + 1'b1;
    end
  end

endmodule
